// File: rtl/glitch_sequencer_if.sv
// Control, configuration and status bundle between a glitch-schedule owner
// and the glitch_sequencer that drives the clock glitch mux.
interface glitch_sequencer_if #(
    parameter int CNT_W  = 16,
    parameter int RPT_W  = 4,
    parameter int MODE_W = 8
) ();
    logic              arm;
    logic              abort;
    logic              trigger;
    logic [CNT_W-1:0]  cfg_delay;
    logic [CNT_W-1:0]  cfg_width;
    logic [CNT_W-1:0]  cfg_gap;
    logic [RPT_W-1:0]  cfg_repeat;
    logic [MODE_W-1:0] cfg_mode;
    logic              glitch_en;
    logic [MODE_W-1:0] glitch_mode;
    logic              armed;
    logic              busy;
    logic              done;

    modport master (
        output arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_mode,
        input  glitch_en, glitch_mode, armed, busy, done
    );

    modport slave (
        input  arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_mode,
        output glitch_en, glitch_mode, armed, busy, done
    );
endinterface

// File: rtl/glitch_sequencer.sv
// Timed glitch-injection controller: after arm and a trigger edge, waits a delay,
// then emits (repeat+1) glitch pulses of a set width separated by a set gap.
module glitch_sequencer #(
    parameter int CNT_W  = 16,
    parameter int RPT_W  = 4,
    parameter int MODE_W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    glitch_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_GLITCH = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0]  RPT_ZERO  = {RPT_W{1'b0}};
    localparam logic [RPT_W-1:0]  RPT_ONE   = {{(RPT_W-1){1'b0}}, 1'b1};
    localparam logic [MODE_W-1:0] MODE_ZERO = {MODE_W{1'b0}};

    state_t            state_r;
    logic              trig_s1_r;
    logic              trig_s2_r;
    logic              trig_s3_r;
    logic              edge_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  delay_r;
    logic [CNT_W-1:0]  width_r;
    logic [CNT_W-1:0]  gap_r;
    logic [RPT_W-1:0]  rpt_r;
    logic [MODE_W-1:0] mode_r;
    logic [CNT_W-1:0]  width_load_s;
    logic [CNT_W-1:0]  gap_load_s;
    logic              glitch_en_r;
    logic [MODE_W-1:0] glitch_mode_r;
    logic              armed_r;
    logic              busy_r;
    logic              done_r;

    // A zero width or gap behaves as one cycle, so the reload value saturates at 0.
    assign width_load_s = (width_r == CNT_ZERO) ? CNT_ZERO : (width_r - CNT_ONE);
    assign gap_load_s   = (gap_r   == CNT_ZERO) ? CNT_ZERO : (gap_r   - CNT_ONE);
    assign edge_s       = trig_s2_r & ~trig_s3_r;

    assign bus.glitch_en   = glitch_en_r;
    assign bus.glitch_mode = glitch_mode_r;
    assign bus.armed       = armed_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;

    // Trigger synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_r <= 1'b0;
            trig_s2_r <= 1'b0;
            trig_s3_r <= 1'b0;
        end else begin
            trig_s1_r <= bus.trigger;
            trig_s2_r <= trig_s1_r;
            trig_s3_r <= trig_s2_r;
        end
    end

    // Sequencer FSM with registered outputs that change on the same edge as the state.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            delay_r       <= CNT_ZERO;
            width_r       <= CNT_ZERO;
            gap_r         <= CNT_ZERO;
            rpt_r         <= RPT_ZERO;
            mode_r        <= MODE_ZERO;
            glitch_en_r   <= 1'b0;
            glitch_mode_r <= MODE_ZERO;
            armed_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else if (bus.abort) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            glitch_en_r   <= 1'b0;
            glitch_mode_r <= MODE_ZERO;
            armed_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.arm) begin
                        delay_r <= bus.cfg_delay;
                        width_r <= bus.cfg_width;
                        gap_r   <= bus.cfg_gap;
                        rpt_r   <= bus.cfg_repeat;
                        mode_r  <= bus.cfg_mode;
                        state_r <= ST_ARMED;
                        armed_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (edge_s) begin
                        armed_r <= 1'b0;
                        if (delay_r == CNT_ZERO) begin
                            state_r       <= ST_GLITCH;
                            cnt_r         <= width_load_s;
                            glitch_en_r   <= 1'b1;
                            glitch_mode_r <= mode_r;
                        end else begin
                            state_r <= ST_DELAY;
                            cnt_r   <= delay_r - CNT_ONE;
                        end
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r       <= ST_GLITCH;
                        cnt_r         <= width_load_s;
                        glitch_en_r   <= 1'b1;
                        glitch_mode_r <= mode_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_GLITCH: begin
                    if (cnt_r == CNT_ZERO) begin
                        glitch_en_r   <= 1'b0;
                        glitch_mode_r <= MODE_ZERO;
                        if (rpt_r != RPT_ZERO) begin
                            rpt_r   <= rpt_r - RPT_ONE;
                            state_r <= ST_GAP;
                            cnt_r   <= gap_load_s;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= CNT_ZERO;
                    glitch_en_r   <= 1'b0;
                    glitch_mode_r <= MODE_ZERO;
                    armed_r       <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised and directed bench for glitch_sequencer, checked every cycle against
// a schedule model (first-pulse time, period and end time computed arithmetically).
module tb_glitch_sequencer;

    localparam int NC = 100000;

    logic clk_in;
    logic rst_n;

    glitch_sequencer_if #(.CNT_W(16), .RPT_W(4), .MODE_W(8)) bus_if ();

    glitch_sequencer #(.CNT_W(16), .RPT_W(4), .MODE_W(8)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus_if)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   hist [0:NC-1];
    bit   trig_v = 1'b0;

    // model: 0 idle, 1 armed, 2 running a pulse schedule
    int   m_st = 0;
    int   m_delay, m_w, m_g, m_n, m_t0, m_tend;
    logic [7:0] m_mode;
    logic       exp_en, exp_armed, exp_busy, exp_done;
    logic [7:0] exp_mode;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("glitch_en",   {31'd0, bus_if.glitch_en}, {31'd0, exp_en});
        check_eq("glitch_mode", {24'd0, bus_if.glitch_mode}, {24'd0, exp_mode});
        check_eq("armed",       {31'd0, bus_if.armed}, {31'd0, exp_armed});
        check_eq("busy",        {31'd0, bus_if.busy}, {31'd0, exp_busy});
        check_eq("done",        {31'd0, bus_if.done}, {31'd0, exp_done});
    endtask

    // Advance the schedule model across the edge that ends cycle cyc.
    task automatic model_step();
        int  c;
        int  nc;
        bit  edge_v;
        c = cyc;
        edge_v = (c >= 3) && hist[c-2] && !hist[c-3];
        exp_done = 1'b0;
        if (bus_if.abort) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (bus_if.arm) begin
                    m_delay = int'(bus_if.cfg_delay);
                    m_w     = (bus_if.cfg_width == 16'd0) ? 1 : int'(bus_if.cfg_width);
                    m_g     = (bus_if.cfg_gap == 16'd0) ? 1 : int'(bus_if.cfg_gap);
                    m_n     = int'(bus_if.cfg_repeat) + 1;
                    m_mode  = bus_if.cfg_mode;
                    m_st    = 1;
                end
                1: if (edge_v) begin
                    m_t0   = c + 1 + m_delay;
                    m_tend = m_t0 + m_n * m_w + (m_n - 1) * m_g;
                    m_st   = 2;
                end
                2: if (c + 1 == m_tend) begin
                    m_st     = 0;
                    exp_done = 1'b1;
                end
                default: m_st = 0;
            endcase
        end
        nc = c + 1;
        exp_armed = (m_st == 1);
        exp_busy  = (m_st != 0);
        exp_en    = (m_st == 2) && (nc >= m_t0) && (((nc - m_t0) % (m_w + m_g)) < m_w);
        exp_mode  = exp_en ? m_mode : 8'h00;
    endtask

    task automatic cycle(input bit a, input bit ab);
        bus_if.arm     = a;
        bus_if.abort   = ab;
        bus_if.trigger = trig_v;
        hist[cyc]      = trig_v;
        model_step();
        @(negedge clk_in);
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle(1'b0, 1'b0);
    endtask

    task automatic run_until_idle(input int budget);
        int g;
        g = 0;
        while (m_st != 0 && g < budget) begin
            cycle(1'b0, 1'b0);
            g++;
        end
        check_eq("idle_bound_busy", {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic set_cfg(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                           input logic [3:0] r, input logic [7:0] m);
        bus_if.cfg_delay  = d;
        bus_if.cfg_width  = w;
        bus_if.cfg_gap    = g;
        bus_if.cfg_repeat = r;
        bus_if.cfg_mode   = m;
    endtask

    // Called at a falling edge: asserts reset mid-cycle, checks async clearing, releases later.
    task automatic do_reset();
        bus_if.arm     = 1'b0;
        bus_if.abort   = 1'b0;
        trig_v         = 1'b0;
        bus_if.trigger = 1'b0;
        hist[cyc]      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_glitch_en",   {31'd0, bus_if.glitch_en}, 32'd0);
        check_eq("rst_glitch_mode", {24'd0, bus_if.glitch_mode}, 32'd0);
        check_eq("rst_armed",       {31'd0, bus_if.armed}, 32'd0);
        check_eq("rst_busy",        {31'd0, bus_if.busy}, 32'd0);
        check_eq("rst_done",        {31'd0, bus_if.done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            cyc++;
            hist[cyc] = 1'b0;
        end
        rst_n = 1'b1;
        m_st = 0;
        exp_en = 1'b0; exp_mode = 8'h00; exp_armed = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    endtask

    // Raise the trigger and step until the model has seen the edge.
    task automatic fire();
        trig_v = 1'b1;
        idle(3);
    endtask

    initial begin
        rst_n = 1'b1;
        bus_if.arm = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.trigger = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 4'd0, 8'h00);
        do_reset();
        idle(4);

        // single one-cycle pulse, zero delay
        set_cfg(16'd0, 16'd1, 16'd1, 4'd0, 8'h08);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        run_until_idle(20);
        trig_v = 1'b0; idle(4);

        // delayed three-pulse train
        set_cfg(16'd5, 16'd3, 16'd2, 4'd2, 8'h04);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        run_until_idle(40);
        trig_v = 1'b0; idle(4);

        // zero width and gap treated as one; re-arm in the done cycle
        set_cfg(16'd0, 16'd0, 16'd0, 4'd1, 8'hC3);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        set_cfg(16'd1, 16'd2, 16'd1, 4'd0, 8'h11);
        run_to(m_tend);
        cycle(1'b1, 1'b0);
        trig_v = 1'b0; idle(3);
        fire();
        run_until_idle(40);
        trig_v = 1'b0; idle(4);

        // trigger already high at arm must not fire
        trig_v = 1'b1; idle(5);
        set_cfg(16'd0, 16'd2, 16'd1, 4'd0, 8'h5A);
        cycle(1'b1, 1'b0);
        idle(10);
        trig_v = 1'b0; idle(3);
        fire();
        run_until_idle(40);
        trig_v = 1'b0; idle(4);

        // abort in the second glitch cycle, then arm+abort together
        set_cfg(16'd0, 16'd4, 16'd1, 4'd0, 8'h77);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        run_to(m_t0 + 1);
        cycle(1'b0, 1'b1);
        idle(6);
        cycle(1'b1, 1'b1);
        idle(3);
        trig_v = 1'b0; idle(4);

        // config changes and re-arm while busy are ignored; reset mid-gap
        set_cfg(16'd6, 16'd2, 16'd3, 4'd1, 8'h55);
        cycle(1'b1, 1'b0);
        set_cfg(16'd1, 16'd7, 16'd7, 4'd3, 8'hAA);
        idle(2);
        fire();
        cycle(1'b1, 1'b0);
        run_to(m_t0 + 3);
        do_reset();
        idle(4);

        // reset in the middle of a pulse
        set_cfg(16'd2, 16'd5, 16'd1, 4'd0, 8'h99);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        run_to(m_t0 + 2);
        do_reset();
        idle(4);

        // longest delay
        set_cfg(16'hFFFF, 16'd1, 16'd1, 4'd0, 8'h3C);
        cycle(1'b1, 1'b0);
        idle(2);
        fire();
        run_until_idle(70000);
        trig_v = 1'b0; idle(4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_cfg(16'($urandom_range(0, 10)), 16'($urandom_range(0, 4)),
                        16'($urandom_range(0, 4)), 4'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 5) == 0) trig_v = ~trig_v;
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
